// File: rtl/param_gcd.sv
// param_gcd: parametrised binary (Stein) GCD engine.
// One shift or subtract step per clock, start/finished handshake plus busy.
// Optional feature macro: PARAM_GCD_CYCLES_EN adds the `cycles` output, which
// counts clocks from accept to finished (saturating).
module param_gcd #(
    parameter int WIDTH   = 32,
    parameter int CYCLE_W = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               start,
    output logic [WIDTH-1:0]   c,
    output logic               finished,
    output logic               busy
`ifdef PARAM_GCD_CYCLES_EN
    ,
    output logic [CYCLE_W-1:0] cycles
`endif
);

    // The common power of two can reach WIDTH-1, so this width always holds it.
    localparam int K_W = $clog2(WIDTH) + 1;

    if (WIDTH < 2 || CYCLE_W < 1) begin : g_param_check
        $error("param_gcd: WIDTH must be >= 2 and CYCLE_W >= 1");
    end

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        REDUCE = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic [K_W-1:0]   k;
    logic             accept;
    logic             both_even;

    assign accept    = (state == IDLE) && start;
    assign both_even = !x[0] && !y[0];

    // State register; reset returns to IDLE from any state.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode and handshake outputs.
    always_comb begin
        state_next = state;
        finished   = 1'b0;
        busy       = 1'b1;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    if (a == '0 || b == '0) begin
                        state_next = DONE;
                    end else begin
                        state_next = SHIFT;
                    end
                end
            end
            SHIFT: begin
                if (!both_even) begin
                    state_next = REDUCE;
                end
            end
            REDUCE: begin
                if (x == y) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                finished   = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Operand/shift datapath and result register; c only changes on DONE entry or reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            x <= '0;
            y <= '0;
            k <= '0;
            c <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        x <= a;
                        y <= b;
                        k <= '0;
                        // gcd(0,b)=b and gcd(a,0)=a; gcd(0,0) falls out as 0.
                        if (a == '0) begin
                            c <= b;
                        end else if (b == '0) begin
                            c <= a;
                        end
                    end
                end
                SHIFT: begin
                    if (both_even) begin
                        x <= x >> 1;
                        y <= y >> 1;
                        k <= k + 1'b1;
                    end
                end
                REDUCE: begin
                    // Subtraction only ever runs larger-minus-smaller, so no wrap.
                    if (x == y) begin
                        c <= x << k;
                    end else if (!x[0]) begin
                        x <= x >> 1;
                    end else if (!y[0]) begin
                        y <= y >> 1;
                    end else if (x > y) begin
                        x <= x - y;
                    end else begin
                        y <= y - x;
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef PARAM_GCD_CYCLES_EN
    // Accept loads 1 (the first busy cycle), then +1 per SHIFT/REDUCE cycle;
    // DONE and IDLE hold the value, so it reads as accept-to-finished latency.
    always_ff @(posedge clock) begin
        if (reset) begin
            cycles <= '0;
        end else if (accept) begin
            cycles <= CYCLE_W'(1);
        end else if ((state == SHIFT || state == REDUCE) && cycles != '1) begin
            cycles <= cycles + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_param_gcd.sv
// Directed testbench for param_gcd: one WIDTH=32 and one WIDTH=8 instance.
module tb_param_gcd;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset;
    logic [31:0] a32, b32, c32;
    logic        start32, fin32, busy32;
    logic [7:0]  a8, b8, c8;
    logic        start8, fin8, busy8;
`ifdef PARAM_GCD_CYCLES_EN
    logic [15:0] cyc32, cyc8;
`endif

    param_gcd #(.WIDTH(32), .CYCLE_W(16)) dut32 (
        .clock    (clock),
        .reset    (reset),
        .a        (a32),
        .b        (b32),
        .start    (start32),
        .c        (c32),
        .finished (fin32),
        .busy     (busy32)
`ifdef PARAM_GCD_CYCLES_EN
        ,
        .cycles   (cyc32)
`endif
    );

    param_gcd #(.WIDTH(8), .CYCLE_W(16)) dut8 (
        .clock    (clock),
        .reset    (reset),
        .a        (a8),
        .b        (b8),
        .start    (start8),
        .c        (c8),
        .finished (fin8),
        .busy     (busy8)
`ifdef PARAM_GCD_CYCLES_EN
        ,
        .cycles   (cyc8)
`endif
    );

    int checks = 0;
    int errors = 0;

    // Results of the most recent run task.
    logic [31:0] r_c;
    int          r_lat;
    logic        r_done;
    logic        r_fin_after;
    logic        r_busy_after;
    logic [15:0] r_cyc;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Euclid by remainder: independent of the DUT's binary algorithm.
    function automatic logic [31:0] gcd_ref(input logic [31:0] p, input logic [31:0] q);
        logic [31:0] u, v, t;
        u = p;
        v = q;
        while (v != 0) begin
            t = u % v;
            u = v;
            v = t;
        end
        return u;
    endfunction

    task automatic run32(input logic [31:0] av, input logic [31:0] bv, input int budget);
        @(negedge clock);
        a32 = av; b32 = bv; start32 = 1'b1;
        @(negedge clock);
        start32 = 1'b0;
        r_lat = 1;
        while (!fin32 && r_lat < budget) begin
            @(negedge clock);
            r_lat++;
        end
        r_done = fin32;
        r_c    = c32;
        r_cyc  = '0;
`ifdef PARAM_GCD_CYCLES_EN
        r_cyc  = cyc32;
`endif
        @(negedge clock);
        r_fin_after  = fin32;
        r_busy_after = busy32;
    endtask

    task automatic run8(input logic [7:0] av, input logic [7:0] bv, input int budget);
        @(negedge clock);
        a8 = av; b8 = bv; start8 = 1'b1;
        @(negedge clock);
        start8 = 1'b0;
        r_lat = 1;
        while (!fin8 && r_lat < budget) begin
            @(negedge clock);
            r_lat++;
        end
        r_done = fin8;
        r_c    = {24'd0, c8};
        @(negedge clock);
        r_fin_after  = fin8;
        r_busy_after = busy8;
    endtask

    initial begin
        logic [7:0]  pa, pb;
        logic [31:0] qa, qb;
        int          saw_fin;

        reset = 1'b1;
        a32 = '0; b32 = '0; start32 = 1'b0;
        a8  = '0; b8  = '0; start8  = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("rst_c",    c32,    32'd0);
        check("rst_fin",  fin32,  1'b0);
        check("rst_busy", busy32, 1'b0);

        // gcd(0,0): finished in the cycle right after accept.
        run32(32'd0, 32'd0, 200);
        check("zz_done", r_done, 1'b1);
        check("zz_lat",  r_lat,  1);
        check("zz_c",    r_c,    32'd0);
        check("zz_busy_after", r_busy_after, 1'b0);

        // gcd(48,18)=6, single pulse, within 4*32+2 cycles, result held.
        run32(32'd48, 32'd18, 200);
        check("g48_done", r_done, 1'b1);
        check("g48_c",    r_c,    32'd6);
        check("g48_lat_ok", (r_lat <= 130), 1'b1);
        check("g48_pulse", r_fin_after, 1'b0);
        check("g48_busy_after", r_busy_after, 1'b0);
        repeat (5) @(negedge clock);
        check("g48_hold", c32, 32'd6);

        run32(32'h8000_0000, 32'h4000_0000, 200);
        check("pow2_c", r_c, 32'h4000_0000);
        check("pow2_lat_ok", (r_done && r_lat <= 130), 1'b1);

        run32(32'hFFFF_FFFF, 32'd1, 200);
        check("max1_c", r_c, 32'd1);
        check("max1_lat_ok", (r_done && r_lat <= 130), 1'b1);

        run32(32'd35, 32'd0, 200);
        check("b0_c",   r_c,   32'd35);
        check("b0_lat", r_lat, 1);

        // start held high: DONE, then IDLE accepts again, then DONE.
        @(negedge clock);
        a32 = 32'd0; b32 = 32'd5; start32 = 1'b1;
        @(negedge clock);
        check("hold_fin1", fin32, 1'b1);
        @(negedge clock);
        check("hold_fin2", fin32, 1'b0);
        check("hold_idle", busy32, 1'b0);
        @(negedge clock);
        check("hold_fin3", fin32, 1'b1);
        start32 = 1'b0;
        @(negedge clock);
        check("hold_busy_end", busy32, 1'b0);
        check("hold_c", c32, 32'd5);

        // start(7,5) while busy on (48,18) must be ignored.
        @(negedge clock);
        a32 = 32'd48; b32 = 32'd18; start32 = 1'b1;
        @(negedge clock);
        start32 = 1'b0;
        @(negedge clock);
        a32 = 32'd7; b32 = 32'd5; start32 = 1'b1;
        @(negedge clock);
        start32 = 1'b0;
        r_lat = 3;
        while (!fin32 && r_lat < 200) begin
            @(negedge clock);
            r_lat++;
        end
        check("busy_ign_done", fin32, 1'b1);
        check("busy_ign_c", c32, 32'd6);
        @(negedge clock);
        check("busy_ign_idle", busy32, 1'b0);

        // Reset in cycle 3 of a run aborts it with no finished pulse.
        saw_fin = 0;
        @(negedge clock);
        a32 = 32'd100; b32 = 32'd75; start32 = 1'b1;
        @(negedge clock);
        start32 = 1'b0;
        if (fin32) saw_fin = 1;
        @(negedge clock);
        if (fin32) saw_fin = 1;
        reset = 1'b1;
        @(negedge clock);
        check("abort_c",    c32,    32'd0);
        check("abort_busy", busy32, 1'b0);
        check("abort_fin",  fin32,  1'b0);
        reset = 1'b0;
        repeat (3) begin
            @(negedge clock);
            if (fin32) saw_fin = 1;
        end
        check("abort_no_pulse", saw_fin, 0);
        run32(32'd7, 32'd5, 200);
        check("after_abort_c", r_c, 32'd1);

        // WIDTH=8 instance: directed values, then a reference-model sweep.
        run8(8'd255, 8'd17, 100);
        check("w8_255_17", r_c, 32'd17);
        check("w8_255_17_lat", (r_done && r_lat <= 34), 1'b1);
        run8(8'd128, 8'd96, 100);
        check("w8_128_96", r_c, 32'd32);
        check("w8_128_96_lat", (r_done && r_lat <= 34), 1'b1);
        run8(8'd255, 8'd255, 100);
        check("w8_255_255", r_c, 32'd255);
        for (int i = 0; i < 40; i++) begin
            pa = 8'($urandom_range(0, 255));
            pb = 8'($urandom_range(0, 255));
            run8(pa, pb, 100);
            check($sformatf("w8_ref_%0d_%0d", pa, pb), r_c, gcd_ref({24'd0, pa}, {24'd0, pb}));
            check($sformatf("w8_lat_%0d_%0d", pa, pb), (r_done && r_lat <= 34), 1'b1);
        end

`ifdef PARAM_GCD_CYCLES_EN
        run32(32'd0, 32'd9, 200);
        check("cyc_zero_c",   r_c,   32'd9);
        check("cyc_zero_cnt", r_cyc, 16'd1);
        run32(32'd48, 32'd18, 200);
        check("cyc_g48_cnt", r_cyc, 16'(r_lat));
        for (int i = 0; i < 300; i++) begin
            qa = $urandom;
            qb = $urandom;
            run32(qa, qb, 200);
            check($sformatf("cyc_ref_%0h_%0h", qa, qb), r_c, gcd_ref(qa, qb));
            check($sformatf("cyc_bound_%0h_%0h", qa, qb), (r_done && r_cyc <= 130), 1'b1);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
